// File: rtl/ghost_render_pkg.sv
// ghost_render_pkg: shared constants, enums and selection helpers for ghost sprite rendering
//   SPR_FRIGHT/SPR_EYES : base sprite_sel codes for frightened and eyes-only frames
//   pal_e               : palette select driven to the colour mapper
//   fetch_state_e       : line-fetch FSM states
package ghost_render_pkg;
  localparam logic [3:0] SPR_FRIGHT = 4'd8;
  localparam logic [3:0] SPR_EYES = 4'd10;
  typedef enum logic [1:0] {PAL_BODY, PAL_BLUE, PAL_WHITE, PAL_EYES} pal_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_LOAD} fetch_state_e;
  // Eyes frames are ordered L,U,R,D to match ghostDir 1..4; no direction falls back to the first one.
  function automatic logic [3:0] sprite_sel(input logic dead, input logic [3:0] dir,
                                            input logic [3:0] fright, input logic [3:0] sprite);
    return dead ? SPR_EYES + ((dir == 4'd0) ? 4'd0 : dir - 4'd1)
         : (fright != 4'd0) ? SPR_FRIGHT + {3'd0, sprite[0]} : sprite;
  endfunction
  function automatic pal_e palette(input logic dead, input logic [3:0] fright);
    return dead ? PAL_EYES : (fright == 4'd1) ? PAL_BLUE : (fright == 4'd2) ? PAL_WHITE : PAL_BODY;
  endfunction
endpackage

// File: rtl/ghost_sprite_renderer.sv
// ghost_sprite_renderer: per-ghost frame snapshot, hblank sprite-row prefetch and pixel output
//   Clk, Reset            : system clock, async active-high reset
//   DrawX, DrawY          : current VGA pixel coordinates
//   ghostPosX/Y, ghost_sprite, ghostDir, is_frightened, is_dead : live ghost controller state
//   rom_addr / rom_data   : external sprite ROM port, {sprite_sel, row} -> 24 px x 2 b
//   ghost_pixel, ghost_color, ghost_palette : per-pixel result for the colour mapper
module ghost_sprite_renderer
  import ghost_render_pkg::*;
#(
  parameter int ROM_LAT = 2,
  parameter int FETCH_X = 640,
  parameter int SNAP_Y = 480,
  parameter int V_TOTAL = 525,
  parameter int PLAY_X0 = 72,
  parameter int PLAY_X1 = 408
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  ghostPosX,
  input  logic [9:0]  ghostPosY,
  input  logic [3:0]  ghost_sprite,
  input  logic [3:0]  ghostDir,
  input  logic [3:0]  is_frightened,
  input  logic        is_dead,
  output logic [8:0]  rom_addr,
  input  logic [47:0] rom_data,
  output logic        ghost_pixel,
  output logic [1:0]  ghost_color,
  output logic [1:0]  ghost_palette
);
  fetch_state_e state, state_n;
  logic [9:0] prev_x, prev_y;
  logic [9:0] snap_x, snap_y;
  logic [3:0] snap_spr, snap_dir, snap_fr;
  logic snap_dead;
  logic [7:0] cnt;
  logic signed [10:0] row_c, row_q;
  logic [3:0] sel_q;
  pal_e pal_f, pal_q;
  logic [47:0] buf_q;
  logic valid;
  logic snap_hit, fetch_hit, row_ok;
  logic [9:0] next_y, col;
  logic [1:0] px;

  assign snap_hit = DrawY == 10'(SNAP_Y) && DrawX == 10'd0 && !(prev_y == 10'(SNAP_Y) && prev_x == 10'd0);
  assign fetch_hit = DrawX == 10'(FETCH_X) && prev_x != 10'(FETCH_X);
  assign next_y = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
  assign row_c = $signed({1'b0, next_y}) - $signed({1'b0, snap_y}) - 11'sd6;
  assign row_ok = !row_q[10] && row_q < 11'sd24;

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= ST_IDLE;
    else state <= state_n;

  always_comb
    state_n = (state == ST_IDLE) ? (fetch_hit ? ST_ADDR : ST_IDLE)
            : (state == ST_ADDR) ? (!row_ok ? ST_IDLE : (ROM_LAT == 1) ? ST_LOAD : ST_WAIT)
            : (state == ST_WAIT) ? ((cnt == 8'(ROM_LAT - 2)) ? ST_LOAD : ST_WAIT)
            : ST_IDLE;

  // Row, sprite and palette are captured on the trigger edge, so a snapshot landing on the
  // same Clk only affects the following fetch.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      prev_x <= '0;
      prev_y <= '0;
      snap_x <= '0;
      snap_y <= '0;
      snap_spr <= '0;
      snap_dir <= '0;
      snap_fr <= '0;
      snap_dead <= 1'b0;
      cnt <= '0;
      row_q <= '0;
      sel_q <= '0;
      pal_f <= PAL_BODY;
      pal_q <= PAL_BODY;
      buf_q <= '0;
      valid <= 1'b0;
      rom_addr <= '0;
    end else begin
      prev_x <= DrawX;
      prev_y <= DrawY;
      if (snap_hit) begin
        snap_x <= ghostPosX;
        snap_y <= ghostPosY;
        snap_spr <= ghost_sprite;
        snap_dir <= ghostDir;
        snap_fr <= is_frightened;
        snap_dead <= is_dead;
      end
      if (state == ST_IDLE && fetch_hit) begin
        row_q <= row_c;
        sel_q <= sprite_sel(snap_dead, snap_dir, snap_fr, snap_spr);
        pal_f <= palette(snap_dead, snap_fr);
      end
      if (state == ST_ADDR) begin
        if (row_ok) rom_addr <= {sel_q, row_q[4:0]};
        else valid <= 1'b0;
      end
      cnt <= (state == ST_WAIT) ? cnt + 8'd1 : 8'd0;
      if (state == ST_LOAD) begin
        buf_q <= rom_data;
        valid <= 1'b1;
        pal_q <= pal_f;
      end
    end

  // Unsigned subtraction: DrawX left of the ghost wraps to a large col and is rejected by col<24.
  assign col = DrawX - snap_x;
  assign px = buf_q[{col[4:0], 1'b0} +: 2];
  assign ghost_pixel = valid && col < 10'd24 && DrawX >= 10'(PLAY_X0) && DrawX < 10'(PLAY_X1) && px != 2'd0;
  assign ghost_color = ghost_pixel ? px : 2'd0;
  assign ghost_palette = pal_q;
endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// tb_ghost_sprite_renderer: directed checks of snapshot, fetch timing, sprite/palette select and clipping
module tb_ghost_sprite_renderer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0, ghostPosX = '0, ghostPosY = '0;
  logic [3:0] ghost_sprite = '0, ghostDir = '0, is_frightened = '0;
  logic is_dead = 1'b0;
  logic [8:0] rom_addr;
  logic [8:0] addr_d = '0;
  logic [47:0] rom_data;
  logic ghost_pixel;
  logic [1:0] ghost_color, ghost_palette;
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  ghost_sprite_renderer dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .ghostPosX(ghostPosX), .ghostPosY(ghostPosY), .ghost_sprite(ghost_sprite),
    .ghostDir(ghostDir), .is_frightened(is_frightened), .is_dead(is_dead),
    .rom_addr(rom_addr), .rom_data(rom_data), .ghost_pixel(ghost_pixel),
    .ghost_color(ghost_color), .ghost_palette(ghost_palette)
  );

  // Sprite ROM with two-cycle latency; pixel i of address a holds (a+i) mod 4.
  function automatic logic [47:0] rom_f(input logic [8:0] a);
    logic [47:0] d;
    d = '0;
    for (int i = 0; i < 24; i++) d[2*i +: 2] = 2'(a + 9'(i));
    return d;
  endfunction
  always @(posedge Clk) addr_d <= rom_addr;
  assign rom_data = rom_f(addr_d);

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y);
    @(negedge Clk);
    DrawX = x;
    DrawY = y;
    @(posedge Clk);
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input logic [9:0] y);
    step(10'd640, y);
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic set_ghost(input logic [9:0] x, input logic [9:0] y, input logic [3:0] spr,
                           input logic [3:0] dir, input logic [3:0] fr, input logic dead);
    ghostPosX = x;
    ghostPosY = y;
    ghost_sprite = spr;
    ghostDir = dir;
    is_frightened = fr;
    is_dead = dead;
    step(10'd0, 10'd480);
  endtask

  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic ep, input logic [1:0] ec);
    step(x, y);
    chk({tag, ".pixel"}, ghost_pixel, ep);
    chk({tag, ".color"}, ghost_color, ec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_addr", rom_addr, 0);
    chk("rst_pixel", ghost_pixel, 0);
    chk("rst_color", ghost_color, 0);
    chk("rst_palette", ghost_palette, 0);
    @(negedge Clk);
    Reset = 1'b0;
    set_ghost(10'd228, 10'd228, 4'd4, 4'd3, 4'd0, 1'b0);
    @(negedge Clk);
    DrawX = 10'd640;
    DrawY = 10'd239;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("fetch_addr", rom_addr, 134);
    @(negedge Clk);
    DrawX = 10'd228;
    @(posedge Clk);
    #1;
    chk("fetch_not_yet", ghost_pixel, 0);
    @(posedge Clk);
    #1;
    chk("fetch_valid", ghost_pixel, 1);
    chk("fetch_color", ghost_color, 2);
    pix("c0", 10'd228, 10'd240, 1'b1, 2'd2);
    pix("c1", 10'd229, 10'd240, 1'b1, 2'd3);
    pix("c2_clear", 10'd230, 10'd240, 1'b0, 2'd0);
    pix("c23", 10'd251, 10'd240, 1'b1, 2'd1);
    pix("c24", 10'd252, 10'd240, 1'b0, 2'd0);
    chk("body_palette", ghost_palette, 0);
    set_ghost(10'd228, 10'd228, 4'd4, 4'd3, 4'd0, 1'b1);
    fetch(10'd239);
    chk("dead_addr", rom_addr, 390);
    pix("dead", 10'd228, 10'd240, 1'b1, 2'd2);
    chk("dead_palette", ghost_palette, 3);
    set_ghost(10'd228, 10'd228, 4'd5, 4'd3, 4'd2, 1'b0);
    fetch(10'd239);
    chk("fright_addr", rom_addr, 294);
    pix("fright", 10'd228, 10'd240, 1'b1, 2'd2);
    chk("fright_palette", ghost_palette, 2);
    @(negedge Clk);
    DrawX = 10'd640;
    DrawY = 10'd239;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    DrawX = 10'd228;
    DrawY = 10'd240;
    #1;
    chk("midrst_addr", rom_addr, 0);
    chk("midrst_palette", ghost_palette, 0);
    chk("midrst_pixel", ghost_pixel, 0);
    chk("midrst_color", ghost_color, 0);
    @(negedge Clk);
    Reset = 1'b0;
    fetch(10'd10);
    chk("post_rst_addr", rom_addr, 5);
    set_ghost(10'd228, 10'd228, 4'd5, 4'd3, 4'd2, 1'b0);
    fetch(10'd239);
    chk("resume_addr", rom_addr, 294);
    pix("resume", 10'd228, 10'd240, 1'b1, 2'd2);
    set_ghost(10'd228, 10'd228, 4'd4, 4'd3, 4'd0, 1'b0);
    ghostPosY = 10'd100;
    fetch(10'd239);
    chk("stale_y_addr", rom_addr, 134);
    pix("stale_y", 10'd228, 10'd240, 1'b1, 2'd2);
    step(10'd0, 10'd480);
    fetch(10'd239);
    pix("new_y_off", 10'd228, 10'd240, 1'b0, 2'd0);
    fetch(10'd105);
    chk("new_y_addr", rom_addr, 128);
    pix("new_y", 10'd229, 10'd106, 1'b1, 2'd1);
    set_ghost(10'd228, 10'd228, 4'd4, 4'd3, 4'd0, 1'b0);
    fetch(10'd256);
    chk("row23_addr", rom_addr, 151);
    pix("row23", 10'd228, 10'd257, 1'b1, 2'd3);
    fetch(10'd257);
    pix("row24_off", 10'd228, 10'd258, 1'b0, 2'd0);
    fetch(10'd233);
    chk("row0_addr", rom_addr, 128);
    pix("row0", 10'd229, 10'd234, 1'b1, 2'd1);
    fetch(10'd232);
    pix("row_neg_off", 10'd229, 10'd233, 1'b0, 2'd0);
    set_ghost(10'd60, 10'd228, 4'd4, 4'd0, 4'd0, 1'b0);
    fetch(10'd239);
    pix("clip_l65", 10'd65, 10'd240, 1'b0, 2'd0);
    pix("clip_l71", 10'd71, 10'd240, 1'b0, 2'd0);
    pix("clip_l72", 10'd72, 10'd240, 1'b1, 2'd2);
    set_ghost(10'd400, 10'd228, 4'd4, 4'd0, 4'd0, 1'b0);
    fetch(10'd239);
    pix("clip_r407", 10'd407, 10'd240, 1'b1, 2'd1);
    pix("clip_r408", 10'd408, 10'd240, 1'b0, 2'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
